// File: rtl/vibrato_pkg.sv
// vibrato_pkg: shared types and constants for the vibrato-enable key path.
//   key_state_t          - debounce FSM state encoding (2-bit)
//   VIB_DEBOUNCE_DEFAULT - default debounce window in clock cycles (20 ms at 50 MHz)
//   VIB_CLK_HZ           - nominal system clock frequency
//   vib_key_pressed()    - normalises a raw key level to 1 = pressed
package vibrato_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  localparam int unsigned VIB_DEBOUNCE_DEFAULT = 1000000;
  localparam int unsigned VIB_CLK_HZ           = 50000000;

  function automatic logic vib_key_pressed(input logic level, input logic active_low);
    return active_low ? ~level : level;
  endfunction

endpackage

// File: rtl/key_sync_2ff.sv
// key_sync_2ff: two-flop synchroniser for an asynchronous key input.
// Ports:
//   clk   - destination clock
//   reset - asynchronous active-high reset; both flops load RESET_VALUE
//   d     - asynchronous input
//   q     - synchronised output (two clocks of latency)
module key_sync_2ff #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vibrato_key_toggle.sv
// vibrato_key_toggle: debounced pushbutton-to-level converter for the vibrato
// enable bit. Each accepted press flips toggle_out; releases never toggle.
// Ports:
//   clk         - system clock
//   reset       - asynchronous active-high reset
//   key_in      - raw, asynchronous, bouncing key
//   toggle_out  - sticky enable level (feeds PIO in_port)
//   press_pulse - one-cycle strobe per accepted press
//   key_stable  - debounced key state, 1 = pressed
module vibrato_key_toggle
  import vibrato_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = VIB_DEBOUNCE_DEFAULT,
  parameter logic        KEY_ACTIVE_LOW  = 1'b1,
  parameter logic        TOGGLE_INIT     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  output logic toggle_out,
  output logic press_pulse,
  output logic key_stable
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic       key_sync;
  logic       p;
  key_state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic       accept;

  // Flops reset to the released level so a key held through reset is seen
  // as a fresh press once reset drops.
  key_sync_2ff #(
    .RESET_VALUE(KEY_ACTIVE_LOW)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (key_in),
    .q    (key_sync)
  );

  assign p = vib_key_pressed(key_sync, KEY_ACTIVE_LOW);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    accept  = 1'b0;
    unique case (state)
      RELEASED: begin
        if (p) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!p) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!p) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (p) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt == CNT_LAST) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RELEASED;
      cnt         <= '0;
      toggle_out  <= TOGGLE_INIT;
      press_pulse <= 1'b0;
      key_stable  <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      press_pulse <= accept;
      if (accept) begin
        toggle_out <= ~toggle_out;
      end
      // Registered from the next state so it moves on the same edge as the toggle.
      key_stable  <= (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end
  end

endmodule

// File: tb/tb_vibrato_key_toggle.sv
// tb_vibrato_key_toggle: scoreboard bench for vibrato_key_toggle with
// DEBOUNCE_CYCLES = 4, active-low key. A sample-history model predicts the
// outputs after each clock; predictions are queued at drive time and
// compared on the following falling edge.
module tb_vibrato_key_toggle;

  localparam int unsigned D = 4;
  localparam logic TINIT = 1'b0;

  typedef struct packed {
    logic toggle;
    logic pulse;
    logic stable;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic key_in;
  logic toggle_out;
  logic press_pulse;
  logic key_stable;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned seg_pulses;

  exp_t sb[$];

  // model state
  logic         m_s1, m_s2;
  logic [D-1:0] m_hist;
  logic         m_stable, m_toggle, m_pulse;

  vibrato_key_toggle #(
    .DEBOUNCE_CYCLES(D),
    .KEY_ACTIVE_LOW (1'b1),
    .TOGGLE_INIT    (TINIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_in     (key_in),
    .toggle_out (toggle_out),
    .press_pulse(press_pulse),
    .key_stable (key_stable)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // The debounced state flips once the last D samples seen by the FSM
  // (key delayed two clocks) all disagree with it.
  task automatic model_step(input logic k, input logic r);
    logic p;
    exp_t e;
    if (r) begin
      m_s1     = 1'b0;
      m_s2     = 1'b0;
      m_hist   = '0;
      m_stable = 1'b0;
      m_toggle = TINIT;
      m_pulse  = 1'b0;
    end else begin
      p       = m_s2;
      m_s2    = m_s1;
      m_s1    = ~k;
      m_hist  = {m_hist[D-2:0], p};
      m_pulse = 1'b0;
      if ((m_stable && m_hist == '0) || (!m_stable && m_hist == '1)) begin
        m_stable = ~m_stable;
        if (m_stable) begin
          m_toggle = ~m_toggle;
          m_pulse  = 1'b1;
        end
      end
    end
    e.toggle = m_toggle;
    e.pulse  = m_pulse;
    e.stable = m_stable;
    sb.push_back(e);
  endtask

  // Called at a falling edge; drives inputs, advances one clock, compares.
  task automatic tick(input logic k, input logic r);
    exp_t e;
    key_in = k;
    reset  = r;
    model_step(k, r);
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      check_eq("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check_eq("toggle_out", toggle_out, e.toggle);
      check_eq("press_pulse", press_pulse, e.pulse);
      check_eq("key_stable", key_stable, e.stable);
    end
    if (press_pulse) seg_pulses++;
  endtask

  task automatic run(input logic k, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick(k, 1'b0);
  endtask

  initial begin
    logic [4:0] bounce;
    reset  = 1'b1;
    key_in = 1'b1;
    model_step(1'b1, 1'b1);
    void'(sb.pop_front());
    @(negedge clk);

    // reset values while reset held, then quiet after release
    seg_pulses = 0;
    for (int unsigned i = 0; i < 3; i++) tick(1'b1, 1'b1);
    run(1'b1, 20);
    check_eq("idle_pulses", seg_pulses, 0);

    // clean press then release
    seg_pulses = 0;
    run(1'b0, 8);
    run(1'b1, 10);
    check_eq("clean_pulses", seg_pulses, 1);
    check_eq("clean_toggle", toggle_out, 1);

    // bouncing press
    seg_pulses = 0;
    bounce = 5'b01010;
    for (int i = 4; i >= 0; i--) tick(bounce[i], 1'b0);
    run(1'b0, 8);
    run(1'b1, 10);
    check_eq("bounce_pulses", seg_pulses, 1);
    check_eq("bounce_toggle", toggle_out, 0);

    // two clean presses
    seg_pulses = 0;
    run(1'b0, 8);
    run(1'b1, 10);
    check_eq("two_mid_toggle", toggle_out, 1);
    run(1'b0, 8);
    run(1'b1, 10);
    check_eq("two_pulses", seg_pulses, 2);
    check_eq("two_toggle", toggle_out, 0);

    // reset during PRESS_WAIT, key kept pressed
    seg_pulses = 0;
    run(1'b0, 4);
    check_eq("midcount_no_pulse", seg_pulses, 0);
    tick(1'b0, 1'b1);
    run(1'b0, 4);
    check_eq("midcount_fresh_wait", seg_pulses, 0);
    run(1'b0, 4);
    check_eq("midcount_pulses", seg_pulses, 1);
    run(1'b1, 10);

    // key held through reset
    seg_pulses = 0;
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    run(1'b0, 12);
    check_eq("held_pulses", seg_pulses, 1);
    check_eq("held_toggle", toggle_out, 1);
    run(1'b1, 10);
    check_eq("held_release_stable", key_stable, 0);
    check_eq("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
